// File: rtl/game_pkg.sv
// game_pkg: shared encodings and helpers for the tic-tac-toe sequencing core.
//   - Cell codes (CELL_EMPTY/CELL_X/CELL_O) and result codes (END_*).
//   - Keypad codes KEY_NONE (no key) and KEY_NEW (new game).
//   - Controller state enum PLAY/CHECK/END.
//   - Grid helpers: per-line owner, winner over all eight lines, full-board test,
//     and a seconds-to-BCD conversion for the timer reload constant.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        END   = 2'd2
    } state_t;

    // Cell i of the packed grid holds key (i+1); entry 0 is the top-left cell.
    typedef logic [8:0][1:0] grid_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    // Winner codes deliberately equal the matching cell codes.
    localparam logic [1:0] END_NONE = 2'b00;
    localparam logic [1:0] END_X    = 2'b01;
    localparam logic [1:0] END_O    = 2'b10;
    localparam logic [1:0] END_DRAW = 2'b11;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_NEW  = 4'h0;

    // Owner of a three-cell line, or CELL_EMPTY if the line is not complete.
    function automatic logic [1:0] line_owner(input logic [1:0] p, input logic [1:0] q,
                                              input logic [1:0] r);
        logic [1:0] owner;
        if ((p != CELL_EMPTY) && (p == q) && (q == r)) begin
            owner = p;
        end else begin
            owner = CELL_EMPTY;
        end
        return owner;
    endfunction

    // First completed line among rows, columns and diagonals.
    function automatic logic [1:0] grid_winner(input grid_t g);
        logic [1:0] w;
        w = line_owner(g[0], g[1], g[2]);
        w = (w != CELL_EMPTY) ? w : line_owner(g[3], g[4], g[5]);
        w = (w != CELL_EMPTY) ? w : line_owner(g[6], g[7], g[8]);
        w = (w != CELL_EMPTY) ? w : line_owner(g[0], g[3], g[6]);
        w = (w != CELL_EMPTY) ? w : line_owner(g[1], g[4], g[7]);
        w = (w != CELL_EMPTY) ? w : line_owner(g[2], g[5], g[8]);
        w = (w != CELL_EMPTY) ? w : line_owner(g[0], g[4], g[8]);
        w = (w != CELL_EMPTY) ? w : line_owner(g[2], g[4], g[6]);
        return w;
    endfunction

    function automatic logic grid_full(input grid_t g);
        logic full;
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            full = full & (g[i] != CELL_EMPTY);
        end
        return full;
    endfunction

    // {tens, ones} BCD of a 0..99 seconds value.
    function automatic logic [7:0] secs_to_bcd(input int unsigned secs);
        return {4'(secs / 32'd10), 4'(secs % 32'd10)};
    endfunction

endpackage

// File: rtl/turn_timer.sv
// turn_timer: per-turn countdown for the game controller.
//   A tick counter runs 0..TICKS_PER_SEC-1 while enabled; each wrap decrements a
//   two-digit BCD seconds pair. A wrap with the pair already at 00 raises
//   timeout for that cycle and reloads the pair. reload has priority over enable.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   enable           count this cycle (controller is in PLAY)
//   reload           restart at TURN_SECONDS with the tick counter cleared
//   time_ten/one     registered BCD seconds remaining
//   timeout          one-cycle pulse, valid in the cycle the countdown expires
module turn_timer
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10,
    parameter int TURN_SECONDS  = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       reload,
    output logic [3:0] time_ten,
    output logic [3:0] time_one,
    output logic       timeout
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0]        RELOAD_BCD = secs_to_bcd(TURN_SECONDS);

    logic [TICK_W-1:0] tick_r;
    logic [3:0]        ten_r;
    logic [3:0]        one_r;
    logic              wrap_s;
    logic              empty_s;

    assign wrap_s   = enable && (tick_r == TICK_LAST);
    assign empty_s  = (ten_r == 4'd0) && (one_r == 4'd0);
    assign timeout  = wrap_s && empty_s && !reload;
    assign time_ten = ten_r;
    assign time_one = one_r;

    // Tick counter and BCD down-counter with borrow from tens into ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_r <= {TICK_W{1'b0}};
            ten_r  <= RELOAD_BCD[7:4];
            one_r  <= RELOAD_BCD[3:0];
        end else if (reload) begin
            tick_r <= {TICK_W{1'b0}};
            ten_r  <= RELOAD_BCD[7:4];
            one_r  <= RELOAD_BCD[3:0];
        end else if (wrap_s) begin
            tick_r <= {TICK_W{1'b0}};
            if (empty_s) begin
                ten_r <= RELOAD_BCD[7:4];
                one_r <= RELOAD_BCD[3:0];
            end else if (one_r == 4'd0) begin
                ten_r <= ten_r - 4'd1;
                one_r <= 4'd9;
            end else begin
                one_r <= one_r - 4'd1;
            end
        end else if (enable) begin
            tick_r <= tick_r + TICK_W'(1);
        end else begin
            tick_r <= tick_r;
        end
    end

endmodule

// File: rtl/game_controller.sv
// game_controller: sequencing core of the tic-tac-toe design.
//   Synchronizes the keypad code, turns F->code transitions into one-cycle press
//   pulses, places X/O marks, alternates turns, detects win/draw and (optionally)
//   runs a per-turn countdown with timeout.
// Build option: define TURN_TIMER_EN to include the turn_timer countdown; without
//   it the time outputs hold TURN_SECONDS and turns change only on valid moves.
// Ports:
//   clock          rising-edge system clock
//   reset          asynchronous active-low reset
//   keypad_buffer  key code: 1..9 cell, 0 new game, F no key, others ignored
//   a1..a9         cell states (00 empty, 01 X, 10 O)
//   game_end       00 playing, 01 X won, 10 O won, 11 draw
//   time_left_ten  BCD tens of seconds remaining
//   time_left_one  BCD ones of seconds remaining
//   turn           0 = X to move, 1 = O to move
module game_controller
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10,
    parameter int TURN_SECONDS  = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keypad_buffer,
    output logic [1:0] a1,
    output logic [1:0] a2,
    output logic [1:0] a3,
    output logic [1:0] a4,
    output logic [1:0] a5,
    output logic [1:0] a6,
    output logic [1:0] a7,
    output logic [1:0] a8,
    output logic [1:0] a9,
    output logic [1:0] game_end,
    output logic [3:0] time_left_ten,
    output logic [3:0] time_left_one,
    output logic       turn
);

    if ((TICKS_PER_SEC < 1) || (TURN_SECONDS < 1) || (TURN_SECONDS > 99)) begin : g_bad_params
        $error("game_controller: TICKS_PER_SEC or TURN_SECONDS out of range");
    end

    logic [3:0] sync1_r;
    logic [3:0] sync2_r;
    logic [3:0] prev_r;
    logic [1:0] fill_r;
    logic       press_r;
    logic [3:0] code_r;
    state_t     state_r;
    grid_t      grid_r;
    logic       turn_r;
    logic [1:0] game_end_r;

    logic [3:0] cell_idx_s;
    logic       move_ok_s;
    logic       new_game_s;
    logic [1:0] win_s;
    logic       full_s;
    logic       timeout_s;

    // Keypad synchronizer and press edge detector. prev_r starts at a non-F
    // value and only follows sync2_r once both stages hold real samples,
    // so a key already held when reset releases never counts as a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= KEY_NONE;
            sync2_r <= KEY_NONE;
            prev_r  <= KEY_NEW;
            fill_r  <= 2'b00;
            press_r <= 1'b0;
            code_r  <= KEY_NONE;
        end else begin
            sync1_r <= keypad_buffer;
            sync2_r <= sync1_r;
            fill_r  <= {fill_r[0], 1'b1};
            prev_r  <= fill_r[1] ? sync2_r : KEY_NEW;
            press_r <= (prev_r == KEY_NONE) && (sync2_r != KEY_NONE);
            code_r  <= sync2_r;
        end
    end

    assign cell_idx_s = code_r - 4'd1;
    assign move_ok_s  = press_r && (code_r >= 4'd1) && (code_r <= 4'd9) &&
                        (grid_r[cell_idx_s] == CELL_EMPTY);
    assign new_game_s = press_r && (code_r == KEY_NEW);
    assign win_s      = grid_winner(grid_r);
    assign full_s     = grid_full(grid_r);

`ifdef TURN_TIMER_EN
    logic timer_en_s;
    logic timer_reload_s;

    assign timer_en_s     = (state_r == PLAY);
    assign timer_reload_s = ((state_r == CHECK) && (win_s == CELL_EMPTY) && !full_s) ||
                            ((state_r == END) && new_game_s);

    turn_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .TURN_SECONDS  (TURN_SECONDS)
    ) u_turn_timer (
        .clock    (clock),
        .reset    (reset),
        .enable   (timer_en_s),
        .reload   (timer_reload_s),
        .time_ten (time_left_ten),
        .time_one (time_left_one),
        .timeout  (timeout_s)
    );
`else
    localparam logic [7:0] FIXED_BCD = secs_to_bcd(TURN_SECONDS);

    assign time_left_ten = FIXED_BCD[7:4];
    assign time_left_one = FIXED_BCD[3:0];
    assign timeout_s     = 1'b0;
`endif

    // Game FSM: move placement, line evaluation, turn/result bookkeeping.
    // A valid move in the same cycle as a timeout takes precedence, so the turn
    // toggles only once (in CHECK).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= PLAY;
            grid_r     <= {9{CELL_EMPTY}};
            turn_r     <= 1'b0;
            game_end_r <= END_NONE;
        end else begin
            case (state_r)
                PLAY: begin
                    if (move_ok_s) begin
                        grid_r[cell_idx_s] <= turn_r ? CELL_O : CELL_X;
                        state_r            <= CHECK;
                    end else if (timeout_s) begin
                        turn_r <= ~turn_r;
                    end else begin
                        state_r <= PLAY;
                    end
                end
                CHECK: begin
                    if (win_s != CELL_EMPTY) begin
                        game_end_r <= win_s;
                        state_r    <= END;
                    end else if (full_s) begin
                        game_end_r <= END_DRAW;
                        state_r    <= END;
                    end else begin
                        turn_r  <= ~turn_r;
                        state_r <= PLAY;
                    end
                end
                END: begin
                    if (new_game_s) begin
                        grid_r     <= {9{CELL_EMPTY}};
                        game_end_r <= END_NONE;
                        turn_r     <= 1'b0;
                        state_r    <= PLAY;
                    end else begin
                        state_r <= END;
                    end
                end
                default: begin
                    state_r <= PLAY;
                end
            endcase
        end
    end

    assign a1       = grid_r[0];
    assign a2       = grid_r[1];
    assign a3       = grid_r[2];
    assign a4       = grid_r[3];
    assign a5       = grid_r[4];
    assign a6       = grid_r[5];
    assign a7       = grid_r[6];
    assign a8       = grid_r[7];
    assign a9       = grid_r[8];
    assign game_end = game_end_r;
    assign turn     = turn_r;

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: self-checking bench for game_controller.
//   A behavioural game model (grid array, seconds counter as an integer, key
//   sample history) predicts every output after every clock edge; directed
//   scenarios add fixed-value checks, then a randomized key stream runs.
module tb_game_controller;

    localparam int TICKS = 10;
    localparam int SECS  = 2;
    localparam int P_PLAY  = 0;
    localparam int P_CHECK = 1;
    localparam int P_END   = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keypad_buffer = 4'hF;
    logic [1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic [1:0] game_end;
    logic [3:0] time_left_ten;
    logic [3:0] time_left_one;
    logic       turn;

    game_controller #(
        .TICKS_PER_SEC (TICKS),
        .TURN_SECONDS  (SECS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .keypad_buffer (keypad_buffer),
        .a1            (a1),
        .a2            (a2),
        .a3            (a3),
        .a4            (a4),
        .a5            (a5),
        .a6            (a6),
        .a7            (a7),
        .a8            (a8),
        .a9            (a9),
        .game_end      (game_end),
        .time_left_ten (time_left_ten),
        .time_left_one (time_left_one),
        .turn          (turn)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_grid[9];
    int m_turn, m_end, m_phase, m_secs, m_tick;
    int m_pulse, m_code, n_samp;
    int h[4];
    int lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                        '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) m_grid[i] = 0;
        for (int i = 0; i < 4; i++) h[i] = 15;
        m_turn = 0; m_end = 0; m_phase = P_PLAY; m_secs = SECS; m_tick = 0;
        m_pulse = 0; m_code = 15; n_samp = 0;
    endfunction

    // Effect of one rising edge, given the key present at that edge.
    function automatic void model_edge(input int k);
        int  old_pulse, old_code, timeout_now, win;
        bit  full;
        old_pulse = m_pulse;
        old_code  = m_code;
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = k;
        n_samp++;
        // A press is seen 2 sync stages later as an F -> non-F step.
        m_pulse = (n_samp >= 4 && h[3] == 15 && h[2] != 15) ? 1 : 0;
        m_code  = h[2];
        timeout_now = 0;
`ifdef TURN_TIMER_EN
        if (m_phase == P_PLAY) begin
            m_tick++;
            if (m_tick == TICKS) begin
                m_tick = 0;
                if (m_secs == 0) begin
                    timeout_now = 1;
                    m_secs = SECS;
                end else begin
                    m_secs--;
                end
            end
        end
`endif
        case (m_phase)
            P_PLAY: begin
                if (old_pulse != 0 && old_code >= 1 && old_code <= 9 && m_grid[old_code-1] == 0) begin
                    m_grid[old_code-1] = (m_turn != 0) ? 2 : 1;
                    m_phase = P_CHECK;
                end else if (timeout_now != 0) begin
                    m_turn ^= 1;
                end
            end
            P_CHECK: begin
                win = 0;
                full = 1;
                foreach (lines[i]) begin
                    if (m_grid[lines[i][0]] != 0 && m_grid[lines[i][0]] == m_grid[lines[i][1]] &&
                        m_grid[lines[i][1]] == m_grid[lines[i][2]]) win = m_grid[lines[i][0]];
                end
                for (int i = 0; i < 9; i++) if (m_grid[i] == 0) full = 0;
                if (win != 0) begin
                    m_end = win; m_phase = P_END;
                end else if (full) begin
                    m_end = 3; m_phase = P_END;
                end else begin
                    m_turn ^= 1; m_phase = P_PLAY; m_secs = SECS; m_tick = 0;
                end
            end
            P_END: begin
                if (old_pulse != 0 && old_code == 0) begin
                    for (int i = 0; i < 9; i++) m_grid[i] = 0;
                    m_end = 0; m_turn = 0; m_phase = P_PLAY; m_secs = SECS; m_tick = 0;
                end
            end
            default: m_phase = P_PLAY;
        endcase
    endfunction

    task automatic compare_all();
        logic [17:0] eg;
        int et, eo;
        for (int i = 0; i < 9; i++) eg[2*i +: 2] = m_grid[i][1:0];
`ifdef TURN_TIMER_EN
        et = m_secs / 10; eo = m_secs % 10;
`else
        et = SECS / 10; eo = SECS % 10;
`endif
        check_eq("grid", 32'({a9, a8, a7, a6, a5, a4, a3, a2, a1}), 32'(eg));
        check_eq("game_end", 32'(game_end), 32'(m_end));
        check_eq("turn", 32'(turn), 32'(m_turn));
        check_eq("time", 32'({time_left_ten, time_left_one}), 32'((et << 4) | eo));
    endtask

    task automatic run_cycle(input logic [3:0] k);
        keypad_buffer = k;
        @(posedge clock);
        if (reset) model_edge(int'(k));
        else model_reset();
        #1;
        compare_all();
    endtask

    task automatic press_key(input logic [3:0] k);
        repeat (4) run_cycle(k);
        repeat (4) run_cycle(4'hF);
    endtask

    task automatic do_reset(input logic [3:0] k);
        keypad_buffer = k;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) run_cycle(k);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] seq_win[5]  = '{4'h1, 4'h5, 4'h2, 4'h4, 4'h3};
        logic [3:0] seq_draw[9] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h4, 4'h6, 4'h8, 4'h7, 4'h9};

        // X wins on the top row, later keys are frozen out, then a new game.
        do_reset(4'hF);
        repeat (4) run_cycle(4'hF);
        foreach (seq_win[i]) press_key(seq_win[i]);
        check_eq("win_row_cells", 32'({a5, a4, a3, a2, a1}), 32'(10'b10_10_01_01_01));
        check_eq("win_x_end", 32'(game_end), 32'(2'b01));
        press_key(4'h6);
        check_eq("end_frozen_a6", 32'(a6), 32'(2'b00));
        press_key(4'h0);
        check_eq("new_game_grid", 32'({a9, a8, a7, a6, a5, a4, a3, a2, a1}), 32'(18'd0));
        check_eq("new_game_end", 32'(game_end), 32'(2'b00));
        check_eq("new_game_turn", 32'(turn), 32'(1'b0));
        check_eq("new_game_time", 32'({time_left_ten, time_left_one}), 32'(8'h02));

        // Occupied cell is ignored and does not pass the turn.
        do_reset(4'hF);
        repeat (4) run_cycle(4'hF);
        press_key(4'h5);
        press_key(4'h5);
        check_eq("occupied_a5", 32'(a5), 32'(2'b01));
        check_eq("occupied_turn", 32'(turn), 32'(1'b1));

        // Full board without a line is a draw.
        do_reset(4'hF);
        repeat (4) run_cycle(4'hF);
        foreach (seq_draw[i]) press_key(seq_draw[i]);
        check_eq("draw_grid", 32'({a9, a8, a7, a6, a5, a4, a3, a2, a1}),
                 32'(18'b01_01_10_10_10_01_01_10_01));
        check_eq("draw_end", 32'(game_end), 32'(2'b11));
        press_key(4'h0);

        // Idle countdown from reset.
        do_reset(4'hF);
        for (int c = 1; c <= 30; c++) begin
            run_cycle(4'hF);
`ifdef TURN_TIMER_EN
            if (c == 10) check_eq("count_01", 32'({time_left_ten, time_left_one}), 32'(8'h01));
            if (c == 20) check_eq("count_00", 32'({time_left_ten, time_left_one}), 32'(8'h00));
            if (c == 30) begin
                check_eq("timeout_turn", 32'(turn), 32'(1'b1));
                check_eq("timeout_time", 32'({time_left_ten, time_left_one}), 32'(8'h02));
            end
`else
            if (c == 30) check_eq("no_timer_turn", 32'(turn), 32'(1'b0));
`endif
        end

        // Move lands on the edge where the countdown would expire.
        do_reset(4'hF);
        repeat (26) run_cycle(4'hF);
        repeat (4) run_cycle(4'h5);
        check_eq("coincide_a5", 32'(a5), 32'(2'b01));
        check_eq("coincide_turn_hold", 32'(turn), 32'(1'b0));
        run_cycle(4'h5);
        check_eq("coincide_turn_once", 32'(turn), 32'(1'b1));
        check_eq("coincide_time", 32'({time_left_ten, time_left_one}), 32'(8'h02));
        repeat (4) run_cycle(4'hF);

        // Key held through reset is not a press until released.
        do_reset(4'h5);
        repeat (8) run_cycle(4'h5);
        check_eq("held_no_move", 32'(a5), 32'(2'b00));
        repeat (4) run_cycle(4'hF);
        press_key(4'h5);
        check_eq("held_then_move", 32'(a5), 32'(2'b01));

        // Randomized key stream against the model.
        do_reset(4'hF);
        repeat (4) run_cycle(4'hF);
        for (int it = 0; it < 500; it++) begin
            logic [3:0] k;
            int hold;
            if ($urandom_range(0, 15) < 7) k = 4'hF;
            else k = 4'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 6));
            repeat (hold) run_cycle(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
